// File: rtl/adc_pkg.sv
// Shared definitions for the ADC sequencing controller: state codes, timing
// constants and the saturating-increment helper used by the statistics counters.
package adc_pkg;

  localparam int CNT_W     = 16;
  localparam int STOP_HOLD = 4;

  typedef enum logic [2:0] {
    ST_OFF   = 3'd0,
    ST_WAKE  = 3'd1,
    ST_FLUSH = 3'd2,
    ST_RUN   = 3'd3,
    ST_STOP  = 3'd4
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic hit);
    return (hit && (v != '1)) ? v + 1'b1 : v;
  endfunction

endpackage

// File: rtl/adc_otr_mon.sv
// Over-range monitor: windowed per-channel over-range counts plus sticky flags.
// A partial window is dropped whenever sampling stops.
module adc_otr_mon
  import adc_pkg::*;
#(
  parameter int OTR_WIN = 4096
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             clr,
  input  logic [1:0]       otr,
  output logic [CNT_W-1:0] ovr_a_cnt,
  output logic [CNT_W-1:0] ovr_b_cnt,
  output logic [1:0]       ovr_sticky
);

  logic [CNT_W-1:0] win_cnt;
  logic [CNT_W-1:0] acc_a;
  logic [CNT_W-1:0] acc_b;
  logic             win_last;

  assign win_last = (win_cnt == CNT_W'(OTR_WIN - 1));

  // The last sample of a window is folded into the published count directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt    <= '0;
      acc_a      <= '0;
      acc_b      <= '0;
      ovr_a_cnt  <= '0;
      ovr_b_cnt  <= '0;
      ovr_sticky <= '0;
    end else if (clr) begin
      win_cnt    <= '0;
      acc_a      <= '0;
      acc_b      <= '0;
      ovr_a_cnt  <= '0;
      ovr_b_cnt  <= '0;
      ovr_sticky <= '0;
    end else if (run) begin
      ovr_sticky <= ovr_sticky | otr;
      if (win_last) begin
        win_cnt   <= '0;
        acc_a     <= '0;
        acc_b     <= '0;
        ovr_a_cnt <= sat_inc(acc_a, otr[0]);
        ovr_b_cnt <= sat_inc(acc_b, otr[1]);
      end else begin
        win_cnt <= win_cnt + 1'b1;
        acc_a   <= sat_inc(acc_a, otr[0]);
        acc_b   <= sat_inc(acc_b, otr[1]);
      end
    end else begin
      win_cnt <= '0;
      acc_a   <= '0;
      acc_b   <= '0;
    end
  end

endmodule

// File: rtl/adc_ctrl.sv
// Dual-channel ADC sequencer: power-up, settle, flush, stream and shutdown,
// with all ADC pins and the sample-valid strobe driven from registers.
module adc_ctrl
  import adc_pkg::*;
#(
  parameter int WAKE_CYCLES   = 2048,
  parameter int FLUSH_SAMPLES = 8,
  parameter int OTR_WIN       = 4096
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       ch_en,
  input  logic             twos_comp,
  input  logic             dcs_en,
  input  logic             otr_a,
  input  logic             otr_b,
  output logic             pdwn_a,
  output logic             pdwn_b,
  output logic             oeb_a,
  output logic             oeb_b,
  output logic             dfs,
  output logic             dcs,
  output logic [1:0]       sample_en,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] ovr_a_cnt,
  output logic [CNT_W-1:0] ovr_b_cnt,
  output logic [1:0]       ovr_sticky
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] tmr_q, tmr_d;
  logic [1:0]       ch_q, ch_d;
  logic [1:0]       pdwn_q, pdwn_d;
  logic [1:0]       oeb_q, oeb_d;
  logic [1:0]       se_q, se_d;
  logic             go;

  assign go = en && (ch_en != 2'b00);

  // Pin values are derived from the next state so every pin is a plain flop.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    ch_d    = ch_q;
    case (state_q)
      ST_OFF: begin
        if (go) begin
          state_d = ST_WAKE;
          tmr_d   = CNT_W'(WAKE_CYCLES - 1);
          ch_d    = ch_en;
        end
      end
      ST_WAKE: begin
        if (!en) begin
          state_d = ST_STOP;
          tmr_d   = CNT_W'(STOP_HOLD - 1);
        end else if (tmr_q == '0) begin
          state_d = ST_FLUSH;
          tmr_d   = CNT_W'(FLUSH_SAMPLES - 1);
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      ST_FLUSH: begin
        if (!en) begin
          state_d = ST_STOP;
          tmr_d   = CNT_W'(STOP_HOLD - 1);
        end else if (tmr_q == '0) begin
          state_d = ST_RUN;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      ST_RUN: begin
        if (!en) begin
          state_d = ST_STOP;
          tmr_d   = CNT_W'(STOP_HOLD - 1);
        end
      end
      ST_STOP: begin
        if (tmr_q == '0) begin
          state_d = ST_OFF;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      default: state_d = ST_OFF;
    endcase

    pdwn_d = (state_d == ST_OFF) ? 2'b11 : ~ch_d;
    oeb_d  = ((state_d == ST_FLUSH) || (state_d == ST_RUN)) ? ~ch_d : 2'b11;
    se_d   = (state_d == ST_RUN) ? ch_d : 2'b00;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_OFF;
      tmr_q   <= '0;
      ch_q    <= 2'b00;
      pdwn_q  <= 2'b11;
      oeb_q   <= 2'b11;
      se_q    <= 2'b00;
      dfs     <= 1'b0;
      dcs     <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      ch_q    <= ch_d;
      pdwn_q  <= pdwn_d;
      oeb_q   <= oeb_d;
      se_q    <= se_d;
      if ((state_q == ST_OFF) && go) begin
        dfs <= twos_comp;
        dcs <= dcs_en;
      end
    end
  end

  assign state     = state_q;
  assign pdwn_a    = pdwn_q[0];
  assign pdwn_b    = pdwn_q[1];
  assign oeb_a     = oeb_q[0];
  assign oeb_b     = oeb_q[1];
  assign sample_en = se_q;

  // Flags from a channel whose data is not being qualified are not counted.
  adc_otr_mon #(
    .OTR_WIN(OTR_WIN)
  ) u_otr_mon (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (state_q == ST_RUN),
    .clr       (state_q == ST_OFF),
    .otr       ({otr_b, otr_a} & ch_q),
    .ovr_a_cnt (ovr_a_cnt),
    .ovr_b_cnt (ovr_b_cnt),
    .ovr_sticky(ovr_sticky)
  );

endmodule

// File: tb/tb_adc_ctrl.sv
// Self-checking bench for adc_ctrl: timestamp-based reference model checked every
// cycle, directed literal checks, random traffic, and a long-window instance.
module tb_adc_ctrl;

  localparam int W   = 16;
  localparam int F   = 4;
  localparam int WIN = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, twos_comp, dcs_en, otr_a, otr_b;
  logic [1:0]  ch_en;
  logic        pdwn_a, pdwn_b, oeb_a, oeb_b, dfs, dcs;
  logic [1:0]  sample_en, ovr_sticky;
  logic [2:0]  state;
  logic [15:0] ovr_a_cnt, ovr_b_cnt;

  logic        en_big, otr_a_big, otr_b_big, tc_big, dcs_en_big;
  logic [1:0]  ch_big;
  logic        pdwn_a_big, pdwn_b_big, oeb_a_big, oeb_b_big, dfs_big, dcs_big;
  logic [1:0]  se_big, sticky_big;
  logic [2:0]  state_big;
  logic [15:0] cnt_a_big, cnt_b_big;

  int checks   = 0;
  int failures = 0;
  bit cmp_on   = 0;
  int hold     = 0;

  always #5 clk = ~clk;

  adc_ctrl #(.WAKE_CYCLES(W), .FLUSH_SAMPLES(F), .OTR_WIN(WIN)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .ch_en(ch_en), .twos_comp(twos_comp),
    .dcs_en(dcs_en), .otr_a(otr_a), .otr_b(otr_b), .pdwn_a(pdwn_a), .pdwn_b(pdwn_b),
    .oeb_a(oeb_a), .oeb_b(oeb_b), .dfs(dfs), .dcs(dcs), .sample_en(sample_en),
    .state(state), .ovr_a_cnt(ovr_a_cnt), .ovr_b_cnt(ovr_b_cnt), .ovr_sticky(ovr_sticky)
  );

  adc_ctrl #(.WAKE_CYCLES(W), .FLUSH_SAMPLES(F), .OTR_WIN(65535)) dut_big (
    .clk(clk), .rst_n(rst_n), .en(en_big), .ch_en(ch_big), .twos_comp(tc_big),
    .dcs_en(dcs_en_big), .otr_a(otr_a_big), .otr_b(otr_b_big), .pdwn_a(pdwn_a_big),
    .pdwn_b(pdwn_b_big), .oeb_a(oeb_a_big), .oeb_b(oeb_b_big), .dfs(dfs_big),
    .dcs(dcs_big), .sample_en(se_big), .state(state_big), .ovr_a_cnt(cnt_a_big),
    .ovr_b_cnt(cnt_b_big), .ovr_sticky(sticky_big)
  );

  // Reference model: the run is described by the edge it started on and the
  // edge shutdown began on; the phase follows from elapsed edges alone.
  int         cyc, start_at, stop_at, prev_m, m_state, m_cnt_a, m_cnt_b;
  bit         active;
  logic [1:0] m_ch, m_sticky, m_pdwn, m_oeb, m_se, hit;
  logic       m_dfs, m_dcs;
  logic [1:0] win_q[$];

  function automatic int mode_at(int c);
    if (!active) return 0;
    if (stop_at >= 0) return ((c - stop_at) < 4) ? 4 : 0;
    if ((c - start_at) < W) return 1;
    if ((c - start_at) < W + F) return 2;
    return 3;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc = 0; active = 0; start_at = 0; stop_at = -1;
      m_ch = 2'b00; m_dfs = 1'b0; m_dcs = 1'b0;
      m_cnt_a = 0; m_cnt_b = 0; m_sticky = 2'b00;
      win_q.delete();
    end else begin
      cyc++;
      prev_m = mode_at(cyc - 1);
      hit = {otr_b, otr_a} & m_ch;
      if (prev_m == 3) begin
        m_sticky = m_sticky | hit;
        win_q.push_back(hit);
        if (win_q.size() == WIN) begin
          m_cnt_a = 0; m_cnt_b = 0;
          foreach (win_q[i]) begin
            m_cnt_a += int'(win_q[i][0]);
            m_cnt_b += int'(win_q[i][1]);
          end
          if (m_cnt_a > 65535) m_cnt_a = 65535;
          if (m_cnt_b > 65535) m_cnt_b = 65535;
          win_q.delete();
        end
      end else begin
        win_q.delete();
      end
      if (prev_m == 0) begin
        m_cnt_a = 0; m_cnt_b = 0; m_sticky = 2'b00;
        active = 0; stop_at = -1;
        if (en && (ch_en != 2'b00)) begin
          active = 1; start_at = cyc; m_ch = ch_en;
          m_dfs = twos_comp; m_dcs = dcs_en;
        end
      end else if ((prev_m >= 1) && (prev_m <= 3) && !en) begin
        stop_at = cyc;
      end
    end
    m_state = mode_at(cyc);
    m_pdwn  = (m_state == 0) ? 2'b11 : ~m_ch;
    m_oeb   = ((m_state == 2) || (m_state == 3)) ? ~m_ch : 2'b11;
    m_se    = (m_state == 3) ? m_ch : 2'b00;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_on) begin
      checkOutput("m.state", 32'(state), 32'(m_state));
      checkOutput("m.pdwn", 32'({pdwn_b, pdwn_a}), 32'(m_pdwn));
      checkOutput("m.oeb", 32'({oeb_b, oeb_a}), 32'(m_oeb));
      checkOutput("m.sample_en", 32'(sample_en), 32'(m_se));
      checkOutput("m.dfs_dcs", 32'({dcs, dfs}), 32'({m_dcs, m_dfs}));
      checkOutput("m.ovr_a", 32'(ovr_a_cnt), 32'(m_cnt_a));
      checkOutput("m.ovr_b", 32'(ovr_b_cnt), 32'(m_cnt_b));
      checkOutput("m.sticky", 32'(ovr_sticky), 32'(m_sticky));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus();
    if (hold == 0) begin
      en   = ~en;
      hold = en ? $urandom_range(5, 60) : $urandom_range(1, 8);
    end
    hold--;
    ch_en     = 2'($urandom_range(0, 3));
    twos_comp = 1'($urandom_range(0, 1));
    dcs_en    = 1'($urandom_range(0, 1));
    otr_a     = ($urandom_range(0, 3) == 0);
    otr_b     = ($urandom_range(0, 3) == 0);
  endtask

  initial begin
    rst_n = 1'b0; en = 0; ch_en = 2'b00; twos_comp = 0; dcs_en = 0; otr_a = 0; otr_b = 0;
    en_big = 0; ch_big = 2'b01; tc_big = 0; dcs_en_big = 0; otr_a_big = 1; otr_b_big = 0;
    tick(3);
    checkOutput("rst.state", 32'(state), 32'd0);
    checkOutput("rst.pdwn", 32'({pdwn_b, pdwn_a}), 32'd3);
    checkOutput("rst.oeb", 32'({oeb_b, oeb_a}), 32'd3);
    checkOutput("rst.se", 32'(sample_en), 32'd0);
    checkOutput("rst.dfs_dcs", 32'({dcs, dfs}), 32'd0);
    rst_n = 1'b1;
    cmp_on = 1;
    tick(2);

    // Power-up timing with both channels.
    ch_en = 2'b11; twos_comp = 1; dcs_en = 1; en = 1;
    tick(1);
    checkOutput("pu.state_wake", 32'(state), 32'd1);
    checkOutput("pu.pdwn0", 32'({pdwn_b, pdwn_a}), 32'd0);
    checkOutput("pu.dfs_dcs", 32'({dcs, dfs}), 32'd3);
    ch_en = 2'b00; twos_comp = 0; dcs_en = 0;
    tick(W - 1);
    checkOutput("pu.oeb_still1", 32'({oeb_b, oeb_a}), 32'd3);
    tick(1);
    checkOutput("pu.oeb0", 32'({oeb_b, oeb_a}), 32'd0);
    tick(F - 1);
    checkOutput("pu.se_still0", 32'(sample_en), 32'd0);
    tick(1);
    checkOutput("pu.se11", 32'(sample_en), 32'd3);
    checkOutput("pu.dfs_kept", 32'({dcs, dfs}), 32'd3);

    // Over-range window: otr_a on samples 0, 3 and 7.
    for (int k = 0; k < WIN; k++) begin
      otr_a = (k == 0) || (k == 3) || (k == 7);
      tick(1);
      if (k == 6) checkOutput("otr.before_last", 32'(ovr_a_cnt), 32'd0);
    end
    otr_a = 0;
    checkOutput("otr.cnt_a", 32'(ovr_a_cnt), 32'd3);
    checkOutput("otr.cnt_b", 32'(ovr_b_cnt), 32'd0);
    checkOutput("otr.sticky", 32'(ovr_sticky), 32'd1);

    // Shutdown from RUN.
    en = 0;
    tick(1);
    checkOutput("stop.state", 32'(state), 32'd4);
    checkOutput("stop.se", 32'(sample_en), 32'd0);
    checkOutput("stop.oeb", 32'({oeb_b, oeb_a}), 32'd3);
    checkOutput("stop.pdwn", 32'({pdwn_b, pdwn_a}), 32'd0);
    checkOutput("stop.cnt_held", 32'(ovr_a_cnt), 32'd3);
    tick(3);
    checkOutput("stop.state3", 32'(state), 32'd4);
    tick(1);
    checkOutput("off.state", 32'(state), 32'd0);
    checkOutput("off.pdwn", 32'({pdwn_b, pdwn_a}), 32'd3);
    tick(1);
    checkOutput("off.cnt_clr", 32'(ovr_a_cnt), 32'd0);
    checkOutput("off.sticky_clr", 32'(ovr_sticky), 32'd0);

    // Channel A only.
    ch_en = 2'b01; twos_comp = 0; en = 1;
    tick(1);
    checkOutput("cha.pdwn", 32'({pdwn_b, pdwn_a}), 32'd2);
    tick(W + F);
    checkOutput("cha.state", 32'(state), 32'd3);
    checkOutput("cha.se", 32'(sample_en), 32'd1);
    checkOutput("cha.oeb", 32'({oeb_b, oeb_a}), 32'd2);
    en = 0;
    tick(6);

    // en dropped in WAKE, re-raised during STOP with new config.
    ch_en = 2'b11; en = 1;
    tick(1);
    tick(4);
    en = 0;
    tick(1);
    checkOutput("rew.stop", 32'(state), 32'd4);
    en = 1; ch_en = 2'b10; twos_comp = 1; dcs_en = 0;
    tick(3);
    checkOutput("rew.stop_holds", 32'(state), 32'd4);
    tick(1);
    checkOutput("rew.off", 32'(state), 32'd0);
    checkOutput("rew.off_pdwn", 32'({pdwn_b, pdwn_a}), 32'd3);
    tick(1);
    checkOutput("rew.wake", 32'(state), 32'd1);
    checkOutput("rew.pdwn", 32'({pdwn_b, pdwn_a}), 32'd1);
    checkOutput("rew.dfs_dcs", 32'({dcs, dfs}), 32'd1);

    // Asynchronous reset while streaming channel B.
    tick(W + F);
    otr_b = 1;
    tick(3);
    checkOutput("rrun.sticky", 32'(ovr_sticky), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst.state", 32'(state), 32'd0);
    checkOutput("arst.pdwn", 32'({pdwn_b, pdwn_a}), 32'd3);
    checkOutput("arst.oeb", 32'({oeb_b, oeb_a}), 32'd3);
    checkOutput("arst.se", 32'(sample_en), 32'd0);
    checkOutput("arst.sticky", 32'(ovr_sticky), 32'd0);
    #3 rst_n = 1'b1;
    otr_b = 0; en = 0;
    tick(8);

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      applyStimulus();
      tick(1);
    end
    en = 0; otr_a = 0; otr_b = 0;
    tick(8);

    // Long window: no wrap at 65535, cleared again in OFF.
    en_big = 1;
    tick(1);
    checkOutput("big.wake", 32'(state_big), 32'd1);
    tick(W + F);
    checkOutput("big.run", 32'(state_big), 32'd3);
    checkOutput("big.se", 32'(se_big), 32'd1);
    checkOutput("big.oeb", 32'({oeb_b_big, oeb_a_big}), 32'd2);
    checkOutput("big.pdwn", 32'({pdwn_b_big, pdwn_a_big}), 32'd2);
    checkOutput("big.dfs_dcs", 32'({dcs_big, dfs_big}), 32'd0);
    tick(65534);
    checkOutput("big.cnt_pre", 32'(cnt_a_big), 32'd0);
    tick(1);
    checkOutput("big.cnt_win", 32'(cnt_a_big), 32'd65535);
    tick(70000 - 65535);
    checkOutput("big.cnt_nowrap", 32'(cnt_a_big), 32'd65535);
    checkOutput("big.cnt_b", 32'(cnt_b_big), 32'd0);
    checkOutput("big.sticky", 32'(sticky_big), 32'd1);
    en_big = 0;
    tick(5);
    checkOutput("big.off", 32'(state_big), 32'd0);
    tick(1);
    checkOutput("big.cnt_clr", 32'(cnt_a_big), 32'd0);
    checkOutput("big.sticky_clr", 32'(sticky_big), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adc_ctrl.md
# adc_ctrl

Sequencing and monitoring controller for the dual-channel 12-bit ADC interface. It owns the ADC control pins (power-down, output enable, data format, duty-cycle stabiliser) and walks the converter through power-up, settling, streaming and shutdown. It gates a sample-valid strobe to the downstream datapath and reports per-channel over-range statistics. It sits beside the ADC data capture logic, driving its control pins and qualifying its output.

## Interface
- WAKE_CYCLES, 2048: clk cycles from PDWN release to OEB assertion (ADC wake-up time).
- FLUSH_SAMPLES, 8: samples discarded after OEB assertion (pipeline latency plus margin); 1..255.
- OTR_WIN, 4096: over-range statistics window length in samples; 1..65535.
- clk  in  1  ADC sample clock; one sample per cycle.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  run request; level-sensitive.
- ch_en  in  2  channel enable, bit0 = A, bit1 = B; latched on OFF->WAKE.
- twos_comp  in  1  data format request; latched on OFF->WAKE; drives DFS.
- dcs_en  in  1  duty-cycle stabiliser request; latched on OFF->WAKE.
- otr_a, otr_b  in  1  ADC over-range flags, aligned with the data.
- pdwn_a, pdwn_b  out  1  ADC power-down, active high.
- oeb_a, oeb_b  out  1  ADC output enable, active low.
- dfs, dcs  out  1  format and stabiliser pins.
- sample_en  out  2  per-channel sample valid to the datapath.
- state  out  3  current FSM state code.
- ovr_a_cnt, ovr_b_cnt  out  16  over-range count of the last completed window.
- ovr_sticky  out  2  sticky over-range flag per channel; cleared only in OFF.

## Operation
- State codes: OFF = 0, WAKE = 1, FLUSH = 2, RUN = 3, STOP = 4.
- OFF: pdwn = 1 and oeb = 1 for both channels; sample_en = 0; statistics counters cleared.
  - en = 1 latches ch_en, twos_comp and dcs_en.
  - If the latched ch_en = 0, stay in OFF; otherwise go to WAKE.
- WAKE: pdwn of each enabled channel = 0; oeb stays 1. A down-counter runs WAKE_CYCLES cycles, then the FSM goes to FLUSH.
- FLUSH: oeb of each enabled channel = 0. Count FLUSH_SAMPLES cycles with sample_en held at 0, then go to RUN.
- RUN: sample_en = latched ch_en. The over-range monitor is active.
- STOP: sample_en = 0 immediately; oeb = 1. Hold for 4 cycles, then pdwn = 1 and go to OFF.
- en = 0 in WAKE, FLUSH or RUN goes to STOP on the next edge. STOP always completes, even if en returns to 1. OFF re-evaluates en afterwards.
- Disabled channels keep pdwn = 1 and oeb = 1 in every state.
- Config inputs changing outside OFF are ignored until the next run.
- Over-range monitor, active only in RUN:
  - A window counter counts samples 0..OTR_WIN-1.
  - Per-channel accumulators increment when otr_x = 1, saturating at 0xFFFF.
  - On the last sample of the window, ovr_x_cnt is loaded with the accumulator value including that sample, and the accumulator restarts at 0.
  - Any otr_x = 1 in RUN sets ovr_sticky[x].
  - Leaving RUN abandons the partial window. ovr_x_cnt holds its value until OFF, where it clears to 0.

## Timing
- All outputs are registered. Reset values: state = OFF, pdwn = 1, oeb = 1, dfs = 0, dcs = 0, sample_en = 0, ovr_*_cnt = 0, ovr_sticky = 0.
- Reset asserted mid-operation forces the reset values asynchronously. The ADC returns to powered-down and tri-stated with no STOP sequence.
- en sampled at 1 in OFF at edge N:
  - state = WAKE and pdwn = 0 after edge N.
  - oeb = 0 after edge N+WAKE_CYCLES.
  - sample_en = 1 after edge N+WAKE_CYCLES+FLUSH_SAMPLES.
- en sampled at 0 in RUN at edge M:
  - sample_en = 0 and oeb = 1 after edge M.
  - pdwn = 1 and state = OFF after edge M+4.
- dfs and dcs update on the OFF->WAKE edge and are stable for the whole run.
- otr and sample_en are treated as same-cycle; the monitor applies no extra alignment delay.

## Structure
- Shared package adc_pkg:
  - state encoding constants;
  - the STOP hold length (4);
  - counter width constant (16).
- Sub-module adc_otr_mon holds the window counter, the two saturating accumulators and the sticky flags. Its inputs are clk, rst_n, run, clr and otr[1:0]. adc_ctrl contains the FSM and the pin drivers.

## Test plan
- Power-up, ch_en = 2'b11, WAKE_CYCLES = 16, FLUSH_SAMPLES = 4, en rises at edge 10 -> pdwn = 0 after edge 10, oeb = 0 after edge 26, sample_en = 2'b11 after edge 30.
- ch_en = 2'b01 -> pdwn_b and oeb_b stay 1 in every state; sample_en = 2'b01 in RUN.
- en dropped during WAKE, then re-raised during STOP -> STOP holds 4 cycles, returns to OFF, then a fresh WAKE begins with newly latched config.
- OTR_WIN = 8, otr_a high on samples 0, 3 and 7 -> ovr_a_cnt = 3 after sample 7; ovr_sticky[0] = 1; otr_b idle -> ovr_b_cnt = 0.
- otr_a held high for 70000 RUN samples with OTR_WIN = 65535 -> ovr_a_cnt = 65535 for the first window and no wrap. Dropping en to reach OFF then clears ovr_a_cnt and ovr_sticky.
- rst_n asserted in RUN -> same cycle pdwn = 1, oeb = 1, sample_en = 0, state = OFF.
